// File: rtl/fn_arb.sv
// fn_arb: round-robin arbiter sharing one registered bitwise function unit
// (sel=1: a^b, sel=0: a&b) among NREQ requesters. The result is held in a
// single output register and handed to the consumer under valid/ready,
// tagged with the index of the requester that produced it.
//
// Optional build macro: FN_ARB_STAT_EN adds the stall_cnt output, a
// saturating count of edges where a result was valid but not accepted.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   req       per-requester request (bit i = requester i)
//   a, b      operands, requester i at [i*W +: W]
//   sel       per-requester function select (1 = XOR, 0 = AND)
//   gnt       one-hot accept strobe, combinational, same cycle as the transfer
//   y, y_id   registered result and the index that produced it
//   y_vld     result valid
//   y_rdy     consumer ready; result taken when y_vld & y_rdy
//   stall_cnt (FN_ARB_STAT_EN only) 16-bit saturating stall counter
`timescale 1ns/1ps
module fn_arb #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a,
  input  logic [NREQ*W-1:0] b,
  input  logic [NREQ-1:0]   sel,
  output logic [NREQ-1:0]   gnt,
  output logic [W-1:0]      y,
  output logic [IW-1:0]     y_id,
  output logic              y_vld,
  input  logic              y_rdy
`ifdef FN_ARB_STAT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  logic [W-1:0]  y_reg;
  logic [IW-1:0] y_id_reg;
  logic          y_vld_reg;
  logic [IW-1:0] ptr_reg;
  logic [IW-1:0] ptr_next;

  logic [W-1:0]  res_arr [NREQ];
  logic [IW-1:0] win_idx;
  logic [IW-1:0] scan_idx;
  logic          win_found;
  logic          can_accept;
  logic          grant;

  // Every requester's candidate result is formed in parallel; the winner's
  // is selected below.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_fn
      assign res_arr[gi] = sel[gi] ? (a[gi*W +: W] ^ b[gi*W +: W])
                                   : (a[gi*W +: W] & b[gi*W +: W]);
    end
  endgenerate

  // Scan from ptr upward; NREQ is a power of two so the IW-bit add wraps
  // naturally modulo NREQ.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = ptr_reg + IW'(k);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // A full register can be refilled on the same edge it drains, which is
  // what gives one result per cycle under a steady y_rdy.
  assign can_accept = !y_vld_reg || y_rdy;
  assign grant      = rst_n && can_accept && win_found;
  assign gnt        = grant ? (NREQ'(1) << win_idx) : '0;
  assign ptr_next   = win_idx + IW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_reg     <= '0;
      y_id_reg  <= '0;
      y_vld_reg <= 1'b0;
      ptr_reg   <= '0;
    end else if (grant) begin
      y_reg     <= res_arr[win_idx];
      y_id_reg  <= win_idx;
      y_vld_reg <= 1'b1;
      ptr_reg   <= ptr_next;
    end else if (y_vld_reg && y_rdy) begin
      // Drain only; y and y_id keep their last values.
      y_vld_reg <= 1'b0;
    end
  end

  assign y     = y_reg;
  assign y_id  = y_id_reg;
  assign y_vld = y_vld_reg;

`ifdef FN_ARB_STAT_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (y_vld_reg && !y_rdy && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule
